// File: rtl/dac_stream_pkg.sv
// Shared types and constants for the DAC stream gain/ramp block.
// No ports. Provides:
//   - the ramp state encoding
//   - default AXIS, sample and gain widths
//   - saturation limits and the rounding constant used by the lane scaler
package dac_stream_pkg;

  localparam int DEF_AXIS_DATA_WIDTH = 256;
  localparam int DEF_DAC_DATA_WIDTH  = 16;
  localparam int DEF_GAIN_WIDTH      = 18;
  localparam int DEF_GAIN_FRAC_BITS  = 16;

  localparam int SAMPLES_PER_BEAT = DEF_AXIS_DATA_WIDTH / DEF_DAC_DATA_WIDTH;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  // Half an LSB of the output, so the product rounds half toward +infinity.
  localparam int ROUND_CONST = 2 ** (DEF_GAIN_FRAC_BITS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    ACTIVE    = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_e;

endpackage

// File: rtl/dac_stream_gain_ramp_scaler.sv
// dac_sample_scaler: one sample lane of the gain pipeline.
// Stage 1 registers the signed product sample * {0, gain}.
// Stage 2 registers the rounded and saturated sample plus a clip flag.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   i_en               pipeline advance; both stages hold when low
//   i_sample           signed input sample
//   i_gain             unsigned fixed-point gain
//   o_sample           rounded, saturated signed sample
//   o_clip             the registered sample was saturated
module dac_sample_scaler
  import dac_stream_pkg::*;
#(
  parameter int DW     = DEF_DAC_DATA_WIDTH,
  parameter int GW     = DEF_GAIN_WIDTH,
  parameter int FRAC   = DEF_GAIN_FRAC_BITS,
  parameter int RND    = ROUND_CONST,
  parameter int SAT_HI = SAT_MAX,
  parameter int SAT_LO = SAT_MIN
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [DW-1:0] i_sample,
  input  logic [GW-1:0] i_gain,
  output logic [DW-1:0] o_sample,
  output logic          o_clip
);

  // Product width: signed sample times a zero-extended (positive) gain.
  localparam int PW = DW + GW + 1;
  localparam int RW = PW - FRAC;

  localparam logic signed [PW-1:0] RND_C = PW'(RND);
  localparam logic signed [RW-1:0] HI_C  = RW'(SAT_HI);
  localparam logic signed [RW-1:0] LO_C  = RW'(SAT_LO);

  logic signed [PW-1:0] r_prod;
  logic signed [PW-1:0] w_rnd_sum;
  logic signed [PW-1:0] w_shifted;
  logic signed [RW-1:0] w_rounded;
  logic [DW-1:0]        w_sat;
  logic                 w_clip;
  logic [DW-1:0]        r_sat;
  logic                 r_clip;

  always_comb begin
    w_rnd_sum = r_prod + RND_C;
    w_shifted = w_rnd_sum >>> FRAC;
    w_rounded = w_shifted[RW-1:0];
    w_clip    = 1'b0;
    w_sat     = w_rounded[DW-1:0];
    if (w_rounded > HI_C) begin
      w_sat  = HI_C[DW-1:0];
      w_clip = 1'b1;
    end else if (w_rounded < LO_C) begin
      w_sat  = LO_C[DW-1:0];
      w_clip = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_sat  <= '0;
      r_clip <= 1'b0;
    end else if (i_en) begin
      r_prod <= PW'($signed(i_sample)) * PW'($signed({1'b0, i_gain}));
      r_sat  <= w_sat;
      r_clip <= w_clip;
    end
  end

  assign o_sample = r_sat;
  assign o_clip   = r_clip;

endmodule

// File: rtl/dac_stream_gain_ramp.sv
// dac_stream_gain_ramp: scales each AXIS beat of signed DAC samples by a
// ramped gain, with rounding, saturation and sticky clip tracking.
// Ports:
//   axis_CLK, axis_RESETn            clock, synchronous active-low reset
//   s_axis_TDATA/TVALID/TREADY       sample beats from the streamer
//   m_axis_TDATA/TVALID/TREADY       scaled beats to the DAC
//   enable                           1 ramps gain to target, 0 ramps to 0
//   gainTarget, rampStep             target gain and per-clock step (0 = jump)
//   clipClear                        pulse clearing the sticky clip flag
//   gainCurrent, state, clipped      status
//
// Ramp FSM:
//   state     | meaning
//   IDLE      | gain held at 0, beats pass through as zeros
//   RAMP_UP   | gain stepping up toward gainTarget
//   ACTIVE    | gain tracks gainTarget (stepped, clamped)
//   RAMP_DOWN | gain stepping down toward 0
//
// Pipeline: input reg -> product reg -> round/sat reg -> output reg,
// all advancing together on w_adv, so a beat appears 3 advances after accept.
module dac_stream_gain_ramp
  import dac_stream_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = DEF_AXIS_DATA_WIDTH,
  parameter int DAC_DATA_WIDTH  = DEF_DAC_DATA_WIDTH,
  parameter int GAIN_WIDTH      = DEF_GAIN_WIDTH,
  parameter int GAIN_FRAC_BITS  = DEF_GAIN_FRAC_BITS
) (
  input  logic                       axis_CLK,
  input  logic                       axis_RESETn,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_TDATA,
  input  logic                       s_axis_TVALID,
  output logic                       s_axis_TREADY,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_TDATA,
  output logic                       m_axis_TVALID,
  input  logic                       m_axis_TREADY,
  input  logic                       enable,
  input  logic [GAIN_WIDTH-1:0]      gainTarget,
  input  logic [GAIN_WIDTH-1:0]      rampStep,
  input  logic                       clipClear,
  output logic [GAIN_WIDTH-1:0]      gainCurrent,
  output logic [1:0]                 state,
  output logic                       clipped
);

  localparam int LANES = AXIS_DATA_WIDTH / DAC_DATA_WIDTH;
  localparam int GW    = GAIN_WIDTH;

  ramp_state_e               r_state;
  logic [GW-1:0]             r_gain;
  logic                      r_clipped;

  logic                      w_adv;
  logic                      r_v1;
  logic                      r_v2;
  logic                      r_v3;
  logic [AXIS_DATA_WIDTH-1:0] r_s1_data;
  logic [GW-1:0]             r_s1_gain;
  logic [AXIS_DATA_WIDTH-1:0] w_sat_beat;
  logic [LANES-1:0]          w_lane_clip;
  logic                      r_m_valid;
  logic [AXIS_DATA_WIDTH-1:0] r_m_data;

  // One global advance: every stage moves unless the output is held.
  assign w_adv         = !r_m_valid || m_axis_TREADY;
  assign s_axis_TREADY = axis_RESETn && w_adv;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dac_sample_scaler #(
      .DW   (DAC_DATA_WIDTH),
      .GW   (GW),
      .FRAC (GAIN_FRAC_BITS)
    ) u_scaler (
      .clk      (axis_CLK),
      .rst_n    (axis_RESETn),
      .i_en     (w_adv),
      .i_sample (r_s1_data[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH]),
      .i_gain   (r_s1_gain),
      .o_sample (w_sat_beat[k*DAC_DATA_WIDTH +: DAC_DATA_WIDTH]),
      .o_clip   (w_lane_clip[k])
    );
  end

  always_ff @(posedge axis_CLK) begin
    if (!axis_RESETn) begin
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_v3      <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_s1_data <= '0;
      r_s1_gain <= '0;
      r_clipped <= 1'b0;
    end else begin
      if (w_adv) begin
        // TREADY equals w_adv out of reset, so TVALID alone marks an accept.
        r_v1 <= s_axis_TVALID;
        if (s_axis_TVALID) begin
          r_s1_data <= s_axis_TDATA;
          r_s1_gain <= r_gain;
        end
        r_v2      <= r_v1;
        r_v3      <= r_v2;
        r_m_valid <= r_v3;
        if (r_v3) begin
          r_m_data <= w_sat_beat;
        end
      end
      // A new clip wins over a simultaneous clear.
      if (w_adv && r_v3 && (|w_lane_clip)) begin
        r_clipped <= 1'b1;
      end else if (clipClear) begin
        r_clipped <= 1'b0;
      end
    end
  end

  // Ramp arithmetic is one bit wider than the gain so sums never wrap.
  logic [GW:0]   w_cur_ext;
  logic [GW:0]   w_step_ext;
  logic [GW:0]   w_tgt_ext;
  logic [GW:0]   w_up_sum;
  logic [GW:0]   w_lo_bound;
  logic [GW-1:0] w_up_next;
  logic [GW-1:0] w_down_next;
  logic [GW-1:0] w_toward_lo;

  always_comb begin
    w_cur_ext  = {1'b0, r_gain};
    w_step_ext = {1'b0, rampStep};
    w_tgt_ext  = {1'b0, gainTarget};
    w_up_sum   = w_cur_ext + w_step_ext;
    w_lo_bound = w_tgt_ext + w_step_ext;

    if (rampStep == '0 || w_up_sum >= w_tgt_ext) begin
      w_up_next = gainTarget;
    end else begin
      w_up_next = w_up_sum[GW-1:0];
    end

    if (rampStep == '0 || w_step_ext >= w_cur_ext) begin
      w_down_next = '0;
    end else begin
      w_down_next = r_gain - rampStep;
    end

    // Stepping down onto a lower target in ACTIVE, clamped at the target.
    if (rampStep == '0 || w_cur_ext <= w_lo_bound) begin
      w_toward_lo = gainTarget;
    end else begin
      w_toward_lo = r_gain - rampStep;
    end
  end

  always_ff @(posedge axis_CLK) begin
    if (!axis_RESETn) begin
      r_state <= IDLE;
      r_gain  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_gain <= '0;
          if (enable) begin
            r_state <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!enable) begin
            r_state <= RAMP_DOWN;
          end else begin
            r_gain <= w_up_next;
            if (w_up_next == gainTarget) begin
              r_state <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (!enable) begin
            r_state <= RAMP_DOWN;
          end else if (gainTarget > r_gain) begin
            r_gain <= w_up_next;
          end else if (gainTarget < r_gain) begin
            r_gain <= w_toward_lo;
          end
        end
        RAMP_DOWN: begin
          if (enable) begin
            r_state <= RAMP_UP;
          end else begin
            r_gain <= w_down_next;
            if (w_down_next == '0) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_axis_TDATA  = r_m_data;
  assign m_axis_TVALID = r_m_valid;
  assign gainCurrent   = r_gain;
  assign state         = r_state;
  assign clipped       = r_clipped;

endmodule

// File: doc/dac_stream_gain_ramp.md
Name: dac_stream_gain_ramp

Overview:
- Downstream neighbour of the generic DAC streamer: consumes its AXIS beats (16 x 16-bit signed samples per beat) and feeds the RF DAC AXIS input.
- Applies a per-beat programmable gain with a linear amplitude ramp on start/stop so the DAC never sees a step discontinuity.
- Rounds, saturates and tracks clipping; honours DAC-side backpressure.
- Single clock domain (axis_CLK); control inputs are already synchronous to axis_CLK, forwarded by the existing sys-to-axis forwarding logic.

Parameters:
- AXIS_DATA_WIDTH, 256, beat width on both AXIS sides.
- DAC_DATA_WIDTH, 16, signed sample width.
- GAIN_WIDTH, 18, unsigned gain, fixed point, 1.0 = 2^16 (max about 3.99998).
- GAIN_FRAC_BITS, 16, fractional bits of the gain.

Ports:
- axis_CLK  in  1  sole clock.
- axis_RESETn  in  1  synchronous, active-low reset.
- s_axis_TDATA  in  AXIS_DATA_WIDTH  sample beat; sample k is at bits [16k+15:16k].
- s_axis_TVALID  in  1  input beat valid.
- s_axis_TREADY  out  1  input ready.
- m_axis_TDATA  out  AXIS_DATA_WIDTH  scaled beat to the DAC.
- m_axis_TVALID  out  1  output valid.
- m_axis_TREADY  in  1  DAC ready.
- enable  in  1  level; 1 ramps the gain up to the target, 0 ramps it down to 0.
- gainTarget  in  GAIN_WIDTH  target gain.
- rampStep  in  GAIN_WIDTH  gain change per clock; 0 means jump to the new value immediately.
- clipClear  in  1  one-cycle pulse that clears clipped.
- gainCurrent  out  GAIN_WIDTH  gain presently being applied.
- state  out  2  IDLE=0, RAMP_UP=1, ACTIVE=2, RAMP_DOWN=3.
- clipped  out  1  sticky: set when any sample saturates.

Behaviour:
Reset and handshake
- While axis_RESETn=0 at a clock edge: state=IDLE, gainCurrent=0, clipped=0, m_axis_TVALID=0, m_axis_TDATA=0, all pipeline valid bits cleared.
- Reset mid-operation discards any in-flight beats.
- Pipeline advances when adv = !m_axis_TVALID || m_axis_TREADY.
- s_axis_TREADY = adv, and is 0 while in reset.
- A beat is accepted on s_axis_TVALID && s_axis_TREADY.
- Latency is exactly 3 adv-cycles (accept, multiply, round/saturate, output register); full throughput of one beat per clock.
- When m_axis_TREADY=0 and m_axis_TVALID=1, m_axis_TDATA is held stable and nothing inside the pipeline moves.
- Bubbles on the input propagate as bubbles on the output.

Gain arithmetic
- Each beat captures gainCurrent on the cycle it is accepted; all 16 samples use that gain.
- p = signed sample x {0, gain}, 35-bit signed.
- r = (p + 2^15) >>> 16, i.e. round half toward +infinity.
- Saturate r to [-32768, 32767]. Any lane saturating sets clipped on the cycle the beat reaches the output register.
- clipClear and a new clip in the same cycle: clipped stays 1 (set wins).

Ramp FSM (runs every clock, independent of beat flow)
- IDLE: gainCurrent=0; go to RAMP_UP when enable=1.
- RAMP_UP: gainCurrent = min(gainCurrent + rampStep, gainTarget).
  - Go to ACTIVE on the cycle the result equals gainTarget.
  - If enable=0, go to RAMP_DOWN without updating the gain that cycle.
- ACTIVE: if gainTarget differs from gainCurrent, step toward it by rampStep, clamped at gainTarget (up or down), staying in ACTIVE; if enable=0, go to RAMP_DOWN.
- RAMP_DOWN: gainCurrent = max(gainCurrent - rampStep, 0).
  - Go to IDLE when the result is 0.
  - If enable=1, go to RAMP_UP from the current value.
- rampStep=0 means the next gain value is the endpoint (gainTarget or 0) in one cycle.
- gainTarget=0 with enable=1: RAMP_UP reaches ACTIVE at 0.
- Gain arithmetic is done in GAIN_WIDTH+1 bits to avoid wrap; gainCurrent never exceeds gainTarget while ramping up.
- In IDLE, beats are still accepted and emitted, scaled by 0, so the output is zeros.

Decomposition:
- Package dac_stream_pkg holds:
  - state enum: IDLE, RAMP_UP, ACTIVE, RAMP_DOWN.
  - SAMPLES_PER_BEAT = AXIS_DATA_WIDTH/DAC_DATA_WIDTH.
  - SAT_MAX = 32767, SAT_MIN = -32768.
  - ROUND_CONST = 2^(GAIN_FRAC_BITS-1).
- One sub-module, dac_sample_scaler: a single-lane registered multiply, round and saturate with a clip output, instantiated SAMPLES_PER_BEAT times under the shared adv enable.
- The ramp FSM and handshake stay in the top level.

Test Plan:
- Pass-through: enable=1, gainTarget=0x10000, rampStep=0; beat with lane0=0x1234, lane15=0xFFFF (-1) -> after 3 cycles the output has lane0=0x1234, lane15=0xFFFF, and clipped=0.
- Saturation: gain 0x20000, lanes 0x5000 / 0x8000 -> 0x7FFF / 0x8000, clipped=1; clipClear then clears it; clipClear together with another clipping beat leaves it set.
- Rounding: gain 0x8000 (0.5), lanes 3 / -3 / -1 -> 2 / -1 / 0.
- Ramp: target 0x10000, step 0x4000, enable rises -> gainCurrent 0x4000, 0x8000, 0xC000, 0x10000, then ACTIVE. enable falls -> values step down to 0, then IDLE. Re-asserting enable mid-ramp-down returns to RAMP_UP from the current value.
- Backpressure: continuous input, m_axis_TREADY toggled randomly -> no beat lost or duplicated, m_axis_TDATA stable while stalled, s_axis_TREADY=0 only when the output is full and stalled.
- Reset mid-ramp with 3 beats in flight -> next cycle m_axis_TVALID=0, gainCurrent=0, state=IDLE; the first beat after reset emerges exactly 3 cycles after acceptance.
